// File: rtl/cotm32_pkg.sv
// Shared types and constants for the cotm32 core memory path.
// Holds the LSU access encoding and the memory-port arbiter state/owner types.
package cotm32_pkg;

  localparam int XLEN         = 32;
  localparam int BYTE_WIDTH   = 8;
  localparam int MEM_BE_WIDTH = XLEN / BYTE_WIDTH;

  typedef enum logic [3:0] {
    LSU_NONE,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_ls_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_IFU,
    ARB_OWNER_LSU
  } arb_owner_t;

  function automatic logic is_store(lsu_ls_t op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering between the LSU and a 32-bit word memory.
// Store side builds byte enables and replicated data; load side selects and extends.
module lsu_lane_align
  import cotm32_pkg::*;
(
  input  lsu_ls_t                   i_st_op,
  input  logic [1:0]                i_st_addr_lo,
  input  logic [XLEN-1:0]           i_wdata,
  output logic [MEM_BE_WIDTH-1:0]   o_be,
  output logic [XLEN-1:0]           o_wdata,
  output logic                      o_misaligned,
  input  lsu_ls_t                   i_ld_op,
  input  logic [1:0]                i_ld_addr_lo,
  input  logic [XLEN-1:0]           i_rdata,
  output logic [XLEN-1:0]           o_rdata
);

  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  always_comb begin
    o_be         = '1;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_st_op)
      LSU_SB: begin
        o_be    = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      LSU_SH: begin
        o_be         = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_st_addr_lo[0];
      end
      LSU_SW:          o_misaligned = |i_st_addr_lo;
      LSU_LH, LSU_LHU: o_misaligned = i_st_addr_lo[0];
      LSU_LW:          o_misaligned = |i_st_addr_lo;
      default: ;
    endcase
  end

  // Halfword accesses are 2-byte aligned, so a byte-granular shift also lands halves at bit 0.
  assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_rdata = '0;
    case (i_ld_op)
      LSU_LB:  o_rdata = {{(XLEN-8){w_byte[7]}}, w_byte};
      LSU_LBU: o_rdata = {{(XLEN-8){1'b0}}, w_byte};
      LSU_LH:  o_rdata = {{(XLEN-16){w_half[15]}}, w_half};
      LSU_LHU: o_rdata = {{(XLEN-16){1'b0}}, w_half};
      LSU_LW:  o_rdata = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing each access through a fixed-latency memory with wait states.
module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ifu_req_i,
  input  logic [XLEN-1:0]        ifu_addr_i,
  output logic                   ifu_gnt_o,
  output logic                   ifu_rvalid_o,
  output logic [XLEN-1:0]        ifu_rdata_o,
  input  logic                   lsu_req_i,
  input  cotm32_pkg::lsu_ls_t    lsu_op_i,
  input  logic [XLEN-1:0]        lsu_addr_i,
  input  logic [XLEN-1:0]        lsu_wdata_i,
  output logic                   lsu_gnt_o,
  output logic                   lsu_rvalid_o,
  output logic [XLEN-1:0]        lsu_rdata_o,
  output logic                   lsu_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [XLEN-1:0]        mem_addr_o,
  output logic [3:0]             mem_be_o,
  output logic [XLEN-1:0]        mem_wdata_o,
  input  logic [XLEN-1:0]        mem_rdata_i
);

  import cotm32_pkg::*;

  localparam int unsigned CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

  arb_state_t      r_state;
  arb_state_t      w_next_state;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  arb_owner_t      r_owner;
  arb_owner_t      r_last_owner;
  lsu_ls_t         r_op;
  logic [1:0]      r_addr_lo;
  logic            r_err;

  logic            w_idle;
  logic            w_lsu_req;
  logic            w_grant_lsu;
  logic            w_grant_ifu;
  logic            w_grant;
  logic            w_misaligned;
  logic            w_mem_req;
  logic            w_resp;
  logic [XLEN-1:0] w_addr;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_data;

  lsu_lane_align u_lane_align (
    .i_st_op      (lsu_op_i),
    .i_st_addr_lo (lsu_addr_i[1:0]),
    .i_wdata      (lsu_wdata_i),
    .o_be         (w_be),
    .o_wdata      (w_st_wdata),
    .o_misaligned (w_misaligned),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata_i),
    .o_rdata      (w_ld_data)
  );

  // Gating with rst_n keeps every output quiet while reset is held, even with requests pending.
  assign w_idle      = (r_state == ARB_IDLE) && rst_n;
  assign w_lsu_req   = lsu_req_i && (lsu_op_i != LSU_NONE);
  assign w_grant_lsu = w_idle && w_lsu_req && (!ifu_req_i || (r_last_owner == ARB_OWNER_IFU));
  assign w_grant_ifu = w_idle && ifu_req_i && !w_grant_lsu;
  assign w_grant     = w_grant_lsu || w_grant_ifu;
  assign w_mem_req   = w_grant_ifu || (w_grant_lsu && !w_misaligned);
  assign w_addr      = w_grant_lsu ? lsu_addr_i : ifu_addr_i;

  assign ifu_gnt_o   = w_grant_ifu;
  assign lsu_gnt_o   = w_grant_lsu;
  assign mem_req_o   = w_mem_req;
  assign mem_we_o    = w_grant_lsu && !w_misaligned && is_store(lsu_op_i);
  assign mem_addr_o  = w_mem_req ? {w_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_be_o    = w_mem_req ? (w_grant_lsu ? w_be : 4'b1111) : 4'b0000;
  assign mem_wdata_o = mem_we_o ? w_st_wdata : '0;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) begin
          if ((w_grant_lsu && w_misaligned) || (WAIT_STATES == 0)) begin
            w_next_state = ARB_RESP;
          end else begin
            w_next_state = ARB_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      ARB_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = ARB_RESP;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      ARB_RESP: w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_cnt        <= '0;
      r_owner      <= ARB_OWNER_IFU;
      r_last_owner <= ARB_OWNER_IFU;
      r_op         <= LSU_NONE;
      r_addr_lo    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_grant) begin
        r_owner      <= w_grant_lsu ? ARB_OWNER_LSU : ARB_OWNER_IFU;
        r_last_owner <= w_grant_lsu ? ARB_OWNER_LSU : ARB_OWNER_IFU;
        r_op         <= w_grant_lsu ? lsu_op_i : LSU_NONE;
        r_addr_lo    <= w_addr[1:0];
        r_err        <= w_grant_lsu && w_misaligned;
      end
    end
  end

  assign w_resp       = (r_state == ARB_RESP);
  assign ifu_rvalid_o = w_resp && (r_owner == ARB_OWNER_IFU);
  assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rvalid_o = w_resp && (r_owner == ARB_OWNER_LSU);
  assign lsu_err_o    = lsu_rvalid_o && r_err;
  assign lsu_rdata_o  = (lsu_rvalid_o && !r_err) ? w_ld_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model predicts every
// output each cycle, with directed scenarios pinning the model to hand-computed values.
module tb_mem_port_arbiter;
  import cotm32_pkg::*;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i;
  lsu_ls_t     lsu_op_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(.XLEN(32), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_op_i(lsu_op_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] tbMem [0:255];
  typedef struct {bit valid; logic [31:0] data;} rdEntry_t;
  rdEntry_t rdPipe[$];

  bit          mPending  = 1'b0;
  int          mDue      = 0;
  bit          mOwnerLsu = 1'b0;
  bit          mLastLsu  = 1'b0;
  bit          mErr      = 1'b0;
  logic [31:0] mData     = '0;

  bit          dRst = 1'b0;
  bit          dIfuReq = 1'b0;
  logic [31:0] dIfuAddr = '0;
  bit          dLsuReq = 1'b0;
  lsu_ls_t     dLsuOp = LSU_NONE;
  logic [31:0] dLsuAddr = '0;
  logic [31:0] dLsuWdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got 0x%08h want 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic bit isMisaligned(lsu_ls_t op, logic [1:0] a);
    if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) return (a % 2) != 0;
    if (op == LSU_LW || op == LSU_SW) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] loadValue(lsu_ls_t op, logic [1:0] a, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (op)
      LSU_LB:  return (b >= 128) ? b - 256 : b;
      LSU_LBU: return b;
      LSU_LH:  return (h >= 32768) ? h - 65536 : h;
      LSU_LHU: return h;
      LSU_LW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic anyOutputHigh();
    return ifu_gnt_o | ifu_rvalid_o | (|ifu_rdata_o) | lsu_gnt_o | lsu_rvalid_o |
           (|lsu_rdata_o) | lsu_err_o | mem_req_o | mem_we_o | (|mem_addr_o) |
           (|mem_be_o) | (|mem_wdata_o);
  endfunction

  task automatic applyStimulus();
    rst_n       = dRst;
    ifu_req_i   = dIfuReq;
    ifu_addr_i  = dIfuAddr;
    lsu_req_i   = dLsuReq;
    lsu_op_i    = dLsuOp;
    lsu_addr_i  = dLsuAddr;
    lsu_wdata_i = dLsuWdata;
  endtask

  // Transaction-level prediction: one access in flight, answered 1+WS cycles after its grant.
  task automatic checkOutput();
    logic        eIG, eIV, eLG, eLV, eErr, eReq, eWe;
    logic [31:0] eIData, eLData, eAddr, eWd;
    logic [3:0]  eBe;
    bit          ifuR, lsuR, mis;
    logic [1:0]  a;
    {eIG, eIV, eLG, eLV, eErr, eReq, eWe} = '0;
    {eIData, eLData, eAddr, eWd} = '0;
    eBe = '0;
    if (!rst_n) begin
      mPending = 1'b0;
      mLastLsu = 1'b0;
    end else if (mPending) begin
      if (cyc == mDue) begin
        if (mOwnerLsu) begin eLV = 1'b1; eErr = mErr; eLData = mData; end
        else begin eIV = 1'b1; eIData = mData; end
        mPending = 1'b0;
      end
    end else begin
      ifuR = ifu_req_i;
      lsuR = lsu_req_i && (lsu_op_i != LSU_NONE);
      if (lsuR && (!ifuR || !mLastLsu)) begin
        a = lsu_addr_i[1:0];
        mis = isMisaligned(lsu_op_i, a);
        eLG = 1'b1;
        mPending = 1'b1; mOwnerLsu = 1'b1; mLastLsu = 1'b1; mErr = mis;
        if (mis) begin
          mDue = cyc + 1; mData = '0;
        end else begin
          mDue = cyc + 1 + WS;
          eReq = 1'b1;
          eAddr = lsu_addr_i & 32'hFFFF_FFFC;
          case (lsu_op_i)
            LSU_SB: begin eWe = 1'b1; eBe = 4'(1 << int'(a)); eWd = (lsu_wdata_i & 32'hFF) * 32'h0101_0101; end
            LSU_SH: begin eWe = 1'b1; eBe = (a >= 2) ? 4'd12 : 4'd3; eWd = (lsu_wdata_i & 32'hFFFF) * 32'h0001_0001; end
            LSU_SW: begin eWe = 1'b1; eBe = 4'd15; eWd = lsu_wdata_i; end
            default: eBe = 4'd15;
          endcase
          mData = eWe ? 32'h0 : loadValue(lsu_op_i, a, tbMem[lsu_addr_i[9:2]]);
        end
      end else if (ifuR) begin
        eIG = 1'b1; eReq = 1'b1; eBe = 4'd15;
        eAddr = ifu_addr_i & 32'hFFFF_FFFC;
        mPending = 1'b1; mOwnerLsu = 1'b0; mLastLsu = 1'b0; mErr = 1'b0;
        mDue = cyc + 1 + WS;
        mData = tbMem[ifu_addr_i[9:2]];
      end
    end
    check("ifu_gnt", ifu_gnt_o, eIG);
    check("ifu_rvalid", ifu_rvalid_o, eIV);
    check("ifu_rdata", ifu_rdata_o, eIData);
    check("lsu_gnt", lsu_gnt_o, eLG);
    check("lsu_rvalid", lsu_rvalid_o, eLV);
    check("lsu_err", lsu_err_o, eErr);
    check("lsu_rdata", lsu_rdata_o, eLData);
    check("mem_req", mem_req_o, eReq);
    check("mem_we", mem_we_o, eWe);
    check("mem_addr", mem_addr_o, eAddr);
    check("mem_be", {28'h0, mem_be_o}, {28'h0, eBe});
    check("mem_wdata", mem_wdata_o, eWd);
  endtask

  task automatic presentRdata();
    rdEntry_t e;
    if (rdPipe.size() > WS) begin
      e = rdPipe.pop_front();
      mem_rdata_i = e.valid ? e.data : $urandom;
    end else begin
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic memUpdate();
    rdEntry_t e;
    e.valid = mem_req_o && !mem_we_o;
    e.data  = tbMem[mem_addr_o[9:2]];
    if (mem_req_o && mem_we_o)
      for (int i = 0; i < 4; i++)
        if (mem_be_o[i]) tbMem[mem_addr_o[9:2]][8*i +: 8] = mem_wdata_o[8*i +: 8];
    rdPipe.push_back(e);
  endtask

  task automatic runCycle();
    @(negedge clk);
    presentRdata();
    applyStimulus();
    #1;
    checkOutput();
    memUpdate();
    cyc++;
  endtask

  task automatic lsuAccess(input lsu_ls_t op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic gnt, output logic req, output logic [3:0] be,
                           output logic [31:0] mwd, output int lat, output logic [31:0] rd,
                           output logic err);
    dLsuReq = 1'b1; dLsuOp = op; dLsuAddr = addr; dLsuWdata = wd;
    runCycle();
    gnt = lsu_gnt_o; req = mem_req_o; be = mem_be_o; mwd = mem_wdata_o;
    dLsuReq = 1'b0; dLsuOp = LSU_NONE;
    lat = -1; rd = '0; err = 1'b0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      runCycle();
      if (lsu_rvalid_o) begin lat = i; rd = lsu_rdata_o; err = lsu_err_o; end
    end
  endtask

  task automatic randomNext();
    bit eff;
    if (!dRst) dRst = ($urandom_range(0, 1) == 0);
    else if ($urandom_range(0, 599) == 0) dRst = 1'b0;
    if (dIfuReq && ifu_gnt_o) dIfuReq = 1'b0;
    if (!dIfuReq && $urandom_range(0, 2) == 0) begin
      dIfuReq = 1'b1; dIfuAddr = $urandom_range(0, 1023);
    end
    eff = dLsuReq && (dLsuOp != LSU_NONE);
    if (eff && lsu_gnt_o) eff = 1'b0;
    if (!eff) begin
      dLsuReq   = ($urandom_range(0, 1) == 1);
      dLsuOp    = lsu_ls_t'(4'($urandom_range(0, 8)));
      dLsuAddr  = $urandom_range(0, 1023);
      dLsuWdata = $urandom;
    end
  endtask

  initial begin
    logic        g, r, er;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    int          lat;
    int          nG, nIfuV, nLsuV;
    int          gCyc [8];
    logic        gLsu [8];

    for (int i = 0; i < 256; i++) tbMem[i] = $urandom;
    mem_rdata_i = '0;
    dRst = 1'b0; dIfuReq = 1'b1; dIfuAddr = 32'h20;
    dLsuReq = 1'b1; dLsuOp = LSU_LW; dLsuAddr = 32'h10;
    applyStimulus();

    // Reset held with both sides requesting, then a continuous tie
    runCycle();
    runCycle();
    check("reset_quiet", 32'(anyOutputHigh()), 32'h0);
    dRst = 1'b1;
    nG = 0; nIfuV = 0; nLsuV = 0;
    for (int j = 0; j < 16; j++) begin
      runCycle();
      if ((ifu_gnt_o || lsu_gnt_o) && nG < 8) begin gCyc[nG] = j; gLsu[nG] = lsu_gnt_o; nG++; end
      nIfuV += int'(ifu_rvalid_o);
      nLsuV += int'(lsu_rvalid_o);
    end
    dIfuReq = 1'b0; dLsuReq = 1'b0; dLsuOp = LSU_NONE;
    check("tie_grant_count", nG, 4);
    for (int k = 0; k < 4 && k < nG; k++) check("tie_owner", 32'(gLsu[k]), 32'((k % 2) == 0));
    for (int k = 1; k < 4 && k < nG; k++) check("tie_spacing", gCyc[k] - gCyc[k-1], 2 + WS);
    check("tie_ifu_pulses", nIfuV, 2);
    check("tie_lsu_pulses", nLsuV, 2);
    runCycle();

    // Single fetch
    tbMem[32'h104 >> 2] = 32'h0050_0093;
    dIfuReq = 1'b1; dIfuAddr = 32'h104;
    runCycle();
    check("fetch_gnt", ifu_gnt_o, 1);
    check("fetch_mem_req", mem_req_o, 1);
    check("fetch_addr", mem_addr_o, 32'h104);
    dIfuReq = 1'b0;
    runCycle();
    runCycle();
    runCycle();
    check("fetch_rvalid", ifu_rvalid_o, 1);
    check("fetch_rdata", ifu_rdata_o, 32'h0050_0093);

    // Store lanes
    lsuAccess(LSU_SB, 32'h203, 32'hAB, g, r, be, wd, lat, rd, er);
    check("sb_gnt", g, 1); check("sb_be", be, 4'b1000); check("sb_wdata", wd, 32'hABAB_ABAB);
    check("sb_latency", lat, 1 + WS); check("sb_rdata", rd, 0);
    lsuAccess(LSU_SH, 32'h202, 32'h1234, g, r, be, wd, lat, rd, er);
    check("sh_be", be, 4'b1100); check("sh_wdata", wd, 32'h1234_1234);
    lsuAccess(LSU_SW, 32'h200, 32'hCAFE_F00D, g, r, be, wd, lat, rd, er);
    check("sw_be", be, 4'b1111); check("sw_wdata", wd, 32'hCAFE_F00D);

    // Load extension
    tbMem[32'h300 >> 2] = 32'h80FF_7F01;
    lsuAccess(LSU_LB, 32'h301, 32'h0, g, r, be, wd, lat, rd, er);
    check("lb1", rd, 32'h0000_007F); check("lb1_latency", lat, 1 + WS);
    lsuAccess(LSU_LB, 32'h303, 32'h0, g, r, be, wd, lat, rd, er);
    check("lb3", rd, 32'hFFFF_FF80);
    lsuAccess(LSU_LBU, 32'h302, 32'h0, g, r, be, wd, lat, rd, er);
    check("lbu2", rd, 32'h0000_00FF);
    lsuAccess(LSU_LH, 32'h302, 32'h0, g, r, be, wd, lat, rd, er);
    check("lh2", rd, 32'hFFFF_80FF);
    lsuAccess(LSU_LHU, 32'h302, 32'h0, g, r, be, wd, lat, rd, er);
    check("lhu2", rd, 32'h0000_80FF);

    // Misaligned word load answers one cycle after grant with no memory command
    lsuAccess(LSU_LW, 32'h201, 32'h0, g, r, be, wd, lat, rd, er);
    check("mis_gnt", g, 1); check("mis_mem_req", r, 0);
    check("mis_latency", lat, 1); check("mis_err", er, 1); check("mis_rdata", rd, 0);

    // Reset during the wait phase of a fetch
    dIfuReq = 1'b1; dIfuAddr = 32'h104;
    runCycle();
    dIfuReq = 1'b0;
    runCycle();
    dRst = 1'b0; dIfuReq = 1'b1; dLsuReq = 1'b1; dLsuOp = LSU_LW; dLsuAddr = 32'h300;
    runCycle();
    check("rst_mid_quiet", 32'(anyOutputHigh()), 32'h0);
    runCycle();
    dRst = 1'b1;
    runCycle();
    check("rst_tie_lsu_gnt", lsu_gnt_o, 1);
    check("rst_tie_ifu_gnt", ifu_gnt_o, 0);
    dIfuReq = 1'b0; dLsuReq = 1'b0; dLsuOp = LSU_NONE;
    nIfuV = 0; nLsuV = 0;
    for (int j = 0; j < 6; j++) begin
      runCycle();
      nIfuV += int'(ifu_rvalid_o);
      nLsuV += int'(lsu_rvalid_o);
    end
    check("rst_no_ifu_rvalid", nIfuV, 0);
    check("rst_lsu_rvalid", nLsuV, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      randomNext();
      runCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the IFU (instruction fetch) and the LSU (data load/store). Arbitrates requests, sequences each access through a fixed-latency memory with configurable wait states, generates store byte enables and lane-replicated write data, and returns sign- or zero-extended load data. Sits between the IFU/LSU and the memory macro that holds both `INST_MEM_SIZE` and `DATA_MEM_SIZE` regions.

## Interface
- `XLEN`, 32, data and address width
- `WAIT_STATES`, 0, extra memory cycles beyond one; legal range 0–15

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ifu_req_i`  in  1  fetch request; held with address until granted
- `ifu_addr_i`  in  XLEN  fetch address; bits [1:0] ignored
- `ifu_gnt_o`  out  1  fetch accepted this cycle
- `ifu_rvalid_o`  out  1  one-cycle pulse; `ifu_rdata_o` valid
- `ifu_rdata_o`  out  XLEN  instruction word
- `lsu_req_i`  in  1  data request; held until granted
- `lsu_op_i`  in  `lsu_ls_t`  access type; `LSU_NONE` means no request
- `lsu_addr_i`  in  XLEN  byte address
- `lsu_wdata_i`  in  XLEN  store data, right-aligned
- `lsu_gnt_o`  out  1  data request accepted this cycle
- `lsu_rvalid_o`  out  1  one-cycle completion pulse, loads and stores
- `lsu_rdata_o`  out  XLEN  extended load data; 0 for stores and errors
- `lsu_err_o`  out  1  misaligned access; valid with `lsu_rvalid_o`
- `mem_req_o`  out  1  memory command this cycle
- `mem_we_o`  out  1  write enable
- `mem_addr_o`  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- `mem_be_o`  out  4  byte enables
- `mem_wdata_o`  out  XLEN  lane-replicated write data
- `mem_rdata_i`  in  XLEN  read word; valid exactly 1+`WAIT_STATES` cycles after the command

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`. Reset → `IDLE`.
- `IDLE`:
  - The LSU is requesting when `lsu_req_i` && `lsu_op_i`≠`LSU_NONE`.
  - If one side requests, grant it. If both request, grant the side that was not the last owner.
  - `last_owner` resets to IFU, so the LSU wins the first tie.
  - Grant is combinational: gnt and the `mem_*` command are driven in the same cycle (G).
  - Latch owner, op, addr[1:0] and error flag.
- Next state after G:
  - Misaligned LSU access → `RESP`, no `mem_req_o`. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise, `WAIT_STATES`=0 → `RESP`; else → `WAIT`, loading counter=`WAIT_STATES`-1.
- `WAIT`: decrement the counter; when the counter is 0 → `RESP`.
- `RESP`:
  - Pulse the owner's rvalid.
  - Load data comes from `mem_rdata_i` this cycle: select byte/half by the latched addr[1:0], then extend. B/H sign-extend; BU/HU zero-extend; W passes through.
  - → `IDLE`. No grant is issued in `RESP`.
- Command encoding:
  - IFU and loads: we=0, be=1111.
  - SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=0011 or 1100 by addr[1], wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
- Grants are never issued outside `IDLE`. A requester that is not granted keeps its request asserted.

## Timing
- Reset values: all outputs 0; `mem_addr_o`, `mem_wdata_o`, `ifu_rdata_o` and `lsu_rdata_o` are 0 whenever their valid or req is low.
- Access latency: rvalid in cycle G+1+`WAIT_STATES`. Misaligned access: `lsu_err_o`/`lsu_rvalid_o` in cycle G+1 regardless of `WAIT_STATES`.
- Throughput: one access per 2+`WAIT_STATES` cycles. The earliest next grant is the cycle after `RESP`.
- Reset asserted mid-access: FSM → `IDLE` immediately, pending response dropped, no rvalid emitted. An in-flight memory write may or may not have completed.
- `mem_*` outputs are combinational in cycle G only. `mem_req_o` is never high in `WAIT` or `RESP`.

## Structure
- Package additions to `cotm32_pkg`:
  - `arb_state_t` {`ARB_IDLE`, `ARB_WAIT`, `ARB_RESP`}
  - `arb_owner_t` {`ARB_OWNER_IFU`, `ARB_OWNER_LSU`}
  - `MEM_BE_WIDTH` = `XLEN`/`BYTE_WIDTH`
- Sub-module `lsu_lane_align`, purely combinational:
  - Store direction: op + addr[1:0] + wdata → be/wdata/misaligned.
  - Load direction: op + addr[1:0] + rdata → extended data.
- Arbiter, FSM and counter live in `mem_port_arbiter`.

## Test plan
- **Single fetch**, `WAIT_STATES`=2, IFU req addr 0x104, memory returns 0x00500093:
  - `ifu_gnt_o` and `mem_req_o` in cycle 0 with addr 0x104.
  - `ifu_rvalid_o` with 0x00500093 in cycle 3.
- **Tie and alternation**: both request continuously from reset.
  - Grants go LSU, IFU, LSU, IFU… with spacing 2+`WAIT_STATES` cycles.
  - Each side's rvalid is a single pulse.
- **Store lanes**:
  - SB addr 0x203, wdata 0xAB → be=1000, wdata 0xABABABAB.
  - SH addr 0x202, wdata 0x1234 → be=1100, wdata 0x12341234.
  - SW addr 0x200 → be=1111.
- **Load extension** with memory word 0x80FF7F01:
  - LB @+1 → 0x0000007F; LB @+3 → 0xFFFFFF80; LBU @+2 → 0x000000FF.
  - LH @+2 → 0xFFFF80FF; LHU @+2 → 0x000080FF.
- **Misaligned**: LW addr 0x201, `WAIT_STATES`=3 → no `mem_req_o`; `lsu_rvalid_o` and `lsu_err_o` in cycle G+1; `lsu_rdata_o`=0.
- **Reset mid-access**: drop `rst_n` in the `WAIT` state of an IFU fetch.
  - All outputs 0 immediately; no rvalid after release.
  - First tie after release is granted to the LSU.
